// File: rtl/hs_ctrl_pkg.sv
// Shared handshake-control types: FSM encoding and a one-hot helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hs_ctrl_pkg;

    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT_LO = 2'd2,
        WAIT_HI = 2'd3
    } hs_state_e;

    // Bits at or above nreq are always zero, so callers can slice [nreq-1:0].
    function automatic logic [MAX_NREQ-1:0] onehot(input int id, input int nreq);
        logic [MAX_NREQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            oh[i] = (i < nreq) && (i == id);
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: rotate eligibles by ptr, priority-encode, rotate back.
// Latency: combinational pick; ptr updates on the clock edge that consumes the pick.
// Backpressure: ptr only moves when adv is asserted with a valid pick.
module rr_picker
    import hs_ctrl_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 3
) (
    input  logic           sclk,
    input  logic           rst_n,
    input  logic [N-1:0]   elig,
    input  logic           adv,
    output logic           vld,
    output logic [IDW-1:0] win_id,
    output logic [N-1:0]   win_oh
);

    localparam logic [IDW:0] N_V = (IDW + 1)'(N);

    logic [IDW-1:0]      ptr;
    logic [2*N-1:0]      dbl;
    logic [N-1:0]        rot;
    logic [IDW-1:0]      off;
    logic [IDW:0]        sum;
    logic [MAX_NREQ-1:0] oh_full;

    always_comb begin
        dbl     = {elig, elig} >> ptr;
        rot     = dbl[N-1:0];
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = IDW'(i);
        end
        // Rotate back: ptr + offset, folded into 0..N-1.
        sum     = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_V) sum = sum - N_V;
        win_id  = sum[IDW-1:0];
        vld     = |elig;
        oh_full = onehot(int'(win_id), N);
        win_oh  = vld ? oh_full[N-1:0] : '0;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv && vld) begin
            ptr <= (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
        end
    end

endmodule

// File: rtl/hs_rr_scheduler.sv
// Round-robin front end sharing one sclk->dclk handshake synchronizer among NREQ requesters.
// Latency: 1 sclk from eligible req (with sidle=1) to registered sready/grant/din.
// Backpressure: holds in IDLE while sidle=0; one word in flight until sidle returns high.
module hs_rr_scheduler
    import hs_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 3
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_en,
    input  logic                  sidle,
    output logic                  sready,
    output logic [WIDTH-1:0]      din,
    output logic [NREQ-1:0]       grant,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic                  busy
);

    hs_state_e        state, state_nxt;
    logic             launch;
    logic             finish;
    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic [NREQ-1:0]  pick_oh;
    logic [WIDTH-1:0] pick_word;
    logic [IDW-1:0]   wid;

    rr_picker #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_picker (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .elig   (req & req_en),
        .adv    (launch),
        .vld    (pick_vld),
        .win_id (pick_id),
        .win_oh (pick_oh)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == IDW'(i)) pick_word = req_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld && sidle) begin
                    launch    = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH:  state_nxt = WAIT_LO;
            // A high sidle here is the synchronizer not having seen the launch yet.
            WAIT_LO: if (!sidle) state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (sidle) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // done registers on the return to IDLE, so a relaunch lands one cycle after it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sready  <= 1'b0;
            din     <= '0;
            grant   <= '0;
            done    <= 1'b0;
            done_id <= '0;
            wid     <= '0;
        end else begin
            sready  <= launch;
            grant   <= launch ? pick_oh : '0;
            done    <= finish;
            done_id <= finish ? wid : '0;
            if (launch) begin
                din <= pick_word;
                wid <= pick_id;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_hs_rr_scheduler.sv
// Directed bench for hs_rr_scheduler; the synchronizer is modelled by driving sidle by hand.
`timescale 1ns/1ps
module tb_hs_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 3;

    logic                  sclk     = 1'b0;
    logic                  rst_n    = 1'b0;
    logic [NREQ-1:0]       req      = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_en   = '0;
    logic                  sidle    = 1'b1;
    logic                  sready;
    logic [WIDTH-1:0]      din;
    logic [NREQ-1:0]       grant;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic                  busy;

    int   n_cmp     = 0;
    int   n_err     = 0;
    logic prev_busy = 1'b0;

    always #5 sclk = ~sclk;

    hs_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .req_en   (req_en),
        .sidle    (sidle),
        .sready   (sready),
        .din      (din),
        .grant    (grant),
        .done     (done),
        .done_id  (done_id),
        .busy     (busy)
    );

    // Every launch: one-hot grant alongside sready, and never issued out of a busy cycle.
    always @(negedge sclk) begin
        if (rst_n && (sready || grant != '0)) begin
            n_cmp++;
            if (!(sready && $onehot(grant)) || prev_busy) begin
                n_err++;
                $display("FAIL launch_rule: sready=%b grant=%b prev_busy=%b, need sready=1, one-hot grant, prev_busy=0",
                         sready, grant, prev_busy);
            end
        end
        prev_busy = busy;
    end

    task automatic tick();
        @(negedge sclk);
    endtask

    task automatic wait_sready(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (sready) seen = 1'b1;
        end
    endtask

    // Starts at a launch negedge; drives sidle high for dly, low for lo, then high until done.
    task automatic sync_cycle(input int dly, input int lo, output int spur, output int lat,
                              output logic [IDW-1:0] did);
        spur = 0;
        lat  = -1;
        did  = '0;
        sidle = 1'b1;
        repeat (dly) begin
            tick();
            if (done || sready) spur++;
        end
        sidle = 1'b0;
        repeat (lo) begin
            tick();
            if (done || sready) spur++;
        end
        sidle = 1'b1;
        for (int i = 1; i <= 6 && lat < 0; i++) begin
            tick();
            if (sready) spur++;
            if (done) begin
                lat = i;
                did = done_id;
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        req      = 4'b1111;
        req_en   = 4'b1111;
        sidle    = 1'b1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (3) tick();
        n_cmp++;
        if ({sready, din, grant, done, done_id, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: sready=%b din=%h grant=%b done=%b done_id=%0d busy=%b, need all 0",
                     sready, din, grant, done, done_id, busy);
        end
    endtask

    task automatic test_rr_order();
        bit seen;
        int spur, lat;
        logic [IDW-1:0] did;
        logic [NREQ-1:0] exp_oh;
        logic [WIDTH-1:0] exp_w;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            exp_w  = 8'h10 + 8'(k % 4);
            wait_sready(1, seen);
            n_cmp++;
            if (!seen || grant !== exp_oh || din !== exp_w || busy !== 1'b1) begin
                n_err++;
                $display("FAIL rr_order[%0d]: seen=%b grant=%b din=%h busy=%b, need seen=1 grant=%b din=%h busy=1",
                         k, seen, grant, din, busy, exp_oh, exp_w);
            end
            sync_cycle(1, 2, spur, lat, did);
            if (k == 4) req = '0;
            n_cmp++;
            if (spur != 0 || lat != 1 || did !== IDW'(k % 4)) begin
                n_err++;
                $display("FAIL rr_done[%0d]: spurious=%0d done_lat=%0d done_id=%0d, need 0/1/%0d",
                         k, spur, lat, did, k % 4);
            end
        end
    endtask

    task automatic test_single();
        bit seen;
        int spur, lat;
        logic [IDW-1:0] did;
        req_data = {8'h33, 8'hA5, 8'h11, 8'h00};
        req      = 4'b0100;
        wait_sready(1, seen);
        n_cmp++;
        if (!seen || grant !== 4'b0100 || din !== 8'hA5) begin
            n_err++;
            $display("FAIL single_launch: seen=%b grant=%b din=%h, need 1/0100/a5", seen, grant, din);
        end
        req = '0;
        tick();
        req = 4'b0001;
        n_cmp++;
        if (sready !== 1'b0 || grant !== 4'b0000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_pulse: sready=%b grant=%b busy=%b, need 0/0000/1", sready, grant, busy);
        end
        sync_cycle(1, 10, spur, lat, did);
        req = '0;
        n_cmp++;
        if (spur != 0 || lat != 1 || did !== 3'd2) begin
            n_err++;
            $display("FAIL single_done: spurious=%0d done_lat=%0d done_id=%0d, need 0/1/2", spur, lat, did);
        end
    endtask

    task automatic test_mask();
        bit seen;
        int spur, lat;
        logic [IDW-1:0] did;
        int exp_id;
        req_data = {8'h43, 8'h42, 8'h41, 8'h40};
        req_en   = 4'b1010;
        req      = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            exp_id = (k % 2 == 0) ? 3 : 1;
            wait_sready(1, seen);
            n_cmp++;
            if (!seen || grant !== (4'b0001 << exp_id) || din !== 8'h40 + 8'(exp_id)) begin
                n_err++;
                $display("FAIL mask_grant[%0d]: seen=%b grant=%b din=%h, need requester %0d", k, seen, grant, din, exp_id);
            end
            sync_cycle(1 + k, 2, spur, lat, did);
            if (k == 3) req = '0;
            n_cmp++;
            if (spur != 0 || lat != 1 || did !== IDW'(exp_id)) begin
                n_err++;
                $display("FAIL mask_done[%0d]: spurious=%0d done_lat=%0d done_id=%0d, need 0/1/%0d",
                         k, spur, lat, did, exp_id);
            end
        end
        req_en = 4'b1111;
    endtask

    task automatic test_sidle_hold();
        bit seen;
        int spur, lat, n;
        logic [IDW-1:0] did;
        sidle = 1'b0;
        req   = 4'b1111;
        n     = 0;
        repeat (20) begin
            tick();
            if (sready || busy) n++;
        end
        n_cmp++;
        if (n != 0) begin
            n_err++;
            $display("FAIL sidle_hold: %0d cycles with sready/busy while sidle=0, need 0", n);
        end
        sidle = 1'b1;
        wait_sready(1, seen);
        n_cmp++;
        if (!seen || grant !== 4'b0100 || din !== 8'h42) begin
            n_err++;
            $display("FAIL sidle_release: seen=%b grant=%b din=%h, need 1/0100/42", seen, grant, din);
        end
        sync_cycle(2, 3, spur, lat, did);
        req = '0;
        n_cmp++;
        if (spur != 0 || lat != 1 || did !== 3'd2) begin
            n_err++;
            $display("FAIL sidle_done: spurious=%0d done_lat=%0d done_id=%0d, need 0/1/2", spur, lat, did);
        end
    endtask

    task automatic test_withdraw_glitch();
        bit seen;
        int spur, lat, n;
        logic [IDW-1:0] did;
        sidle = 1'b0;
        req   = 4'b0001;
        repeat (3) tick();
        req   = '0;
        sidle = 1'b1;
        n     = 0;
        repeat (5) begin
            tick();
            if (sready || busy) n++;
        end
        n_cmp++;
        if (n != 0) begin
            n_err++;
            $display("FAIL withdraw: %0d cycles with sready/busy after withdrawal, need 0", n);
        end
        req = 4'b1111;
        wait_sready(1, seen);
        n_cmp++;
        if (!seen || grant !== 4'b1000 || din !== 8'h43) begin
            n_err++;
            $display("FAIL withdraw_ptr: seen=%b grant=%b din=%h, need 1/1000/43", seen, grant, din);
        end
        sync_cycle(5, 2, spur, lat, did);
        req = '0;
        n_cmp++;
        if (spur != 0 || lat != 1 || did !== 3'd3) begin
            n_err++;
            $display("FAIL wait_lo_glitch: spurious=%0d done_lat=%0d done_id=%0d, need 0/1/3", spur, lat, did);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n, spur, lat;
        logic [IDW-1:0] did;
        req = 4'b0100;
        wait_sready(1, seen);
        req   = '0;
        sidle = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (!seen || busy !== 1'b1 || din !== 8'h42) begin
            n_err++;
            $display("FAIL pre_reset: seen=%b busy=%b din=%h, need 1/1/42", seen, busy, din);
        end
        sidle = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sready, din, grant, done, done_id, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_mid: sready=%b din=%h grant=%b done=%b done_id=%0d busy=%b, need all 0",
                     sready, din, grant, done, done_id, busy);
        end
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            tick();
            if (done || sready) n++;
        end
        n_cmp++;
        if (n != 0) begin
            n_err++;
            $display("FAIL reset_no_done: %0d spurious done/sready cycles after reset, need 0", n);
        end
        req = 4'b1111;
        wait_sready(1, seen);
        n_cmp++;
        if (!seen || grant !== 4'b0001 || din !== 8'h40) begin
            n_err++;
            $display("FAIL reset_ptr: seen=%b grant=%b din=%h, need 1/0001/40", seen, grant, din);
        end
        sync_cycle(1, 2, spur, lat, did);
        req = '0;
        n_cmp++;
        if (spur != 0 || lat != 1 || did !== 3'd0) begin
            n_err++;
            $display("FAIL reset_post_done: spurious=%0d done_lat=%0d done_id=%0d, need 0/1/0", spur, lat, did);
        end
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_single();
        test_mask();
        test_sidle_hold();
        test_withdraw_glitch();
        test_reset_mid();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
